// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_t : controller states (IDLE -> RUN -> DONE -> IDLE)
//   cnt_w() : width of the chunk counter, never less than one bit
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to reach WIDTH/STEP-1; a single-chunk build still
  // needs a 1-bit counter so the port of the register is never zero-width.
  function automatic int cnt_w(input int width, input int step);
    int n;
    n = width / step;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// Combinational STEP-bit ripple-carry slice reused every cycle by the
// serial adder.
//   a, b : STEP-bit operand chunks
//   cin  : carry into bit 0
//   s    : STEP-bit chunk sum
//   cout : carry out of the top bit of the chunk
module full_adder_slice #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            cin,
  output logic [STEP-1:0] s,
  output logic            cout
);

  logic [STEP:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < STEP; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[STEP];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle two's-complement adder/subtractor, STEP bits per clock,
// least-significant chunk first, with valid/ready on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (a, b, sub)
//   sub                  : 0 = a+b, 1 = a-b
//   out_valid/out_ready  : result handshake (sum, cout, overflow)
//   sum                  : result modulo 2^WIDTH, held until next completion
//   cout                 : final carry (for subtraction 1 = no borrow)
//   overflow             : signed overflow of the operation
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / STEP;
  localparam int CW     = cnt_w(WIDTH, STEP);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and a multiple of STEP");
  end

  state_t state, state_nxt;

  // a_sh doubles as the result accumulator: operand bits leave at the
  // bottom while sum chunks enter at the top, so after the last chunk it
  // holds the complete result.
  logic [WIDTH-1:0] a_sh, a_nxt;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    count;
  logic             carry;
  logic             msb_a, msb_b;
  logic [STEP-1:0]  sl_s;
  logic             sl_c;
  logic             last;

  full_adder_slice #(.STEP(STEP)) u_slice (
    .a    (a_sh[STEP-1:0]),
    .b    (b_sh[STEP-1:0]),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_c)
  );

  if (STEP == WIDTH) begin : g_one_chunk
    assign a_nxt = sl_s;
  end else begin : g_multi_chunk
    assign a_nxt = {sl_s, a_sh[WIDTH-1:STEP]};
  end

  assign last = (count == LAST);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      msb_a    <= 1'b0;
      msb_b    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here, the +1 is the
            // initial carry.
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= sub;
            count <= '0;
            msb_a <= a[WIDTH-1];
            msb_b <= b[WIDTH-1] ^ sub;
          end
        end
        RUN: begin
          a_sh  <= a_nxt;
          b_sh  <= b_sh >> STEP;
          carry <= sl_c;
          count <= count + CW'(1);
          if (last) begin
            sum      <= a_nxt;
            cout     <= sl_c;
            overflow <= (msb_a == msb_b) && (sl_s[STEP-1] != msb_a);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
